// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like RAM master and its helpers.
package sram_like_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0]  SIZE_BYTE     = 2'd0;
  localparam logic [1:0]  SIZE_HALF     = 2'd1;
  localparam logic [1:0]  SIZE_WORD     = 2'd2;
  localparam logic [3:0]  WSTRB_FULL    = 4'hF;
  localparam logic [31:0] MISALIGN_DATA = 32'hDEADBEEF;

  // Accepted write request held for the duration of one transaction.
  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/wstrb_merge.sv
// Per-byte merge of new write data over an old word under a byte-strobe mask.
module wstrb_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH-1:0]   i_old,
  output logic [DATA_WIDTH-1:0]   o_merged_c
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  always_comb begin
    o_merged_c = i_old;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (i_wstrb[i]) o_merged_c[8*i +: 8] = i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_like_ram_master.sv
// sram-like CPU port to async-read / sync-write RAM, with read-modify-write for sub-word stores.
// Optional misalignment check enabled by defining SRAM_ALIGN_CHECK_EN.
module sram_like_ram_master
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_spo
);

  state_t                r_state;
  state_t                w_state_nxt;
  req_t                  r_req;
  logic                  r_data_ok;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_a;
  logic [DATA_WIDTH-1:0] r_ram_d;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic [DATA_WIDTH-1:0] w_ram_d_nxt;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_unused;

  assign addr_ok  = resetn && ((r_state == ST_IDLE) || (r_state == ST_RESP));
  assign w_accept = req && addr_ok;
  assign w_unused = ^{addr[31:ADDR_WIDTH+2], addr[1:0], size};

`ifdef SRAM_ALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = is_misaligned(size, addr[1:0]);

  // Sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    r_err <= 1'b0;
    else if (w_accept && w_misalign) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign w_misalign = 1'b0;
  assign err        = 1'b0;
`endif

  // Merge samples RAM read data directly at the end of RD, the same edge that captures it.
  wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .i_wstrb    (r_req.wstrb),
    .i_wdata    (r_req.wdata),
    .i_old      (ram_spo),
    .o_merged_c (w_merged)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_ram_d_nxt = r_ram_d;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_misalign) begin
            w_state_nxt = ST_RESP;
            w_rdata_nxt = DATA_WIDTH'(MISALIGN_DATA);
          end else if (!wr) begin
            w_state_nxt = ST_RD;
          end else if (wstrb == WSTRB_FULL) begin
            w_state_nxt = ST_WR;
            w_ram_d_nxt = wdata;
          end else if (wstrb == 4'h0) begin
            w_state_nxt = ST_RESP;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (r_req.wr) begin
          w_state_nxt = ST_WR;
          w_ram_d_nxt = w_merged;
        end else begin
          w_state_nxt = ST_RESP;
          w_rdata_nxt = ram_spo;
        end
      end
      ST_WR: begin
        w_state_nxt = ST_RESP;
        w_rdata_nxt = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req     <= '0;
      r_data_ok <= 1'b0;
      r_ram_we  <= 1'b0;
      r_ram_a   <= '0;
      r_ram_d   <= '0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= (w_state_nxt == ST_RESP);
      r_ram_we  <= (w_state_nxt == ST_WR);
      r_ram_d   <= w_ram_d_nxt;
      r_rdata   <= w_rdata_nxt;
      if (w_accept) begin
        r_req   <= '{wr: wr, wstrb: wstrb, wdata: 32'(wdata)};
        r_ram_a <= addr[ADDR_WIDTH+1:2];
      end
    end
  end

  assign data_ok = r_data_ok;
  assign rdata   = r_rdata;
  assign ram_we  = r_ram_we;
  assign ram_a   = r_ram_a;
  assign ram_d   = r_ram_d;

endmodule

// File: tb/tb_sram_like_ram_master.sv
// Directed bench for sram_like_ram_master: vector table plus back-to-back, reset-in-RMW and misalignment sequences.
module tb_sram_like_ram_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;
  logic        ram_we;
  logic [13:0] ram_a;
  logic [31:0] ram_d;
  logic [31:0] ram_spo;

  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_idx = '0;
  logic [31:0] pl_val = '0;

  int          passed = 0;
  int          total  = 0;
  int          we_total = 0;
  logic [13:0] last_we_a = '0;

  always #5 clk = ~clk;

  sram_like_ram_master #(
    .ADDR_WIDTH (14),
    .DATA_WIDTH (32)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata),
    .err     (err),
    .ram_we  (ram_we),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_spo (ram_spo)
  );

  // RAM model; read data is garbage while writing so an illegal sample shows up.
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    else if (ram_we) mem[ram_a]  <= ram_d;
  end
  assign ram_spo = ram_we ? 32'hBADBAD00 : mem[ram_a];

  always @(negedge clk) begin
    if (ram_we) begin
      we_total  = we_total + 1;
      last_we_a = ram_a;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One transaction from IDLE; returns cycles from accept to data_ok and the response data.
  task automatic txn(input logic i_wr, input logic [1:0] i_size, input logic [3:0] i_strb,
                     input logic [31:0] i_addr, input logic [31:0] i_wdata,
                     output int lat, output logic [31:0] rd);
    int n;
    @(negedge clk);
    req = 1'b1; wr = i_wr; size = i_size; wstrb = i_strb; addr = i_addr; wdata = i_wdata;
    n = 0;
    while (!addr_ok && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!data_ok && lat < 20) begin @(negedge clk); lat++; end
    rd = rdata;
  endtask

  typedef struct {
    logic        pl_en;
    logic [13:0] pl_idx;
    logic [31:0] pl_val;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_we;
    logic [13:0] chk_idx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          lat;
    int          we0;
    int          dok_n;
    int          acc_n;
    int          dok_c [4];
    int          acc_c [4];
    logic [31:0] rd;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_val  [3];

    vecs[0] = '{1'b1, 14'h10,   32'h12345678, 1'b0, 2'd2, 4'h0, 32'h0000_0040, 32'h0,        2, 32'h12345678, 0, 14'h10,   32'h12345678};
    vecs[1] = '{1'b0, 14'h0,    32'h0,        1'b1, 2'd2, 4'hF, 32'h0000_0044, 32'hCAFEF00D, 2, 32'h0,        1, 14'h11,   32'hCAFEF00D};
    vecs[2] = '{1'b0, 14'h0,    32'h0,        1'b0, 2'd2, 4'h0, 32'h0000_0044, 32'h0,        2, 32'hCAFEF00D, 0, 14'h11,   32'hCAFEF00D};
    vecs[3] = '{1'b1, 14'h11,   32'hAABBCCDD, 1'b1, 2'd0, 4'h4, 32'h0000_0046, 32'h00EE0000, 3, 32'h0,        1, 14'h11,   32'hAAEECCDD};
    vecs[4] = '{1'b0, 14'h0,    32'h0,        1'b1, 2'd2, 4'h0, 32'h0000_0044, 32'hFFFFFFFF, 1, 32'h0,        0, 14'h11,   32'hAAEECCDD};
    vecs[5] = '{1'b1, 14'h12,   32'h11223344, 1'b1, 2'd1, 4'h3, 32'h0000_0048, 32'h0000BEEF, 3, 32'h0,        1, 14'h12,   32'h1122BEEF};
    vecs[6] = '{1'b0, 14'h0,    32'h0,        1'b1, 2'd1, 4'hC, 32'h0000_004A, 32'hA5A50000, 3, 32'h0,        1, 14'h12,   32'hA5A5BEEF};
    vecs[7] = '{1'b0, 14'h0,    32'h0,        1'b0, 2'd2, 4'h0, 32'h0001_0044, 32'h0,        2, 32'hAAEECCDD, 0, 14'h11,   32'hAAEECCDD};
    vecs[8] = '{1'b1, 14'h3FFF, 32'h0BADF00D, 1'b1, 2'd2, 4'h9, 32'h0000_FFFC, 32'h11000022, 3, 32'h0,        1, 14'h3FFF, 32'h11ADF022};
    vecs[9] = '{1'b0, 14'h0,    32'h0,        1'b0, 2'd2, 4'h0, 32'h0000_FFFC, 32'h0,        2, 32'h11ADF022, 0, 14'h3FFF, 32'h11ADF022};

    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_addr_ok", 32'(addr_ok), 32'd0);
    chk("rst_data_ok", 32'(data_ok), 32'd0);
    chk("rst_ram_we",  32'(ram_we),  32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_ram_a",   32'(ram_a),   32'd0);
    chk("rst_ram_d",   ram_d,        32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_addr_ok", 32'(addr_ok), 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pl_en) preload(vecs[i].pl_idx, vecs[i].pl_val);
      we0 = we_total;
      txn(vecs[i].wr, vecs[i].size, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, lat, rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_we_cycles", i), 32'(we_total - we0), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we != 0) chk($sformatf("v%0d_we_addr", i), 32'(last_we_a), 32'(vecs[i].chk_idx));
      @(negedge clk);
      chk($sformatf("v%0d_mem", i), mem[vecs[i].chk_idx], vecs[i].exp_mem);
    end
    chk("err_clear", 32'(err), 32'd0);

    // Back-to-back reads with req held high.
    b2b_addr[0] = 32'h80; b2b_addr[1] = 32'h84; b2b_addr[2] = 32'h88;
    b2b_val[0] = 32'h01010101; b2b_val[1] = 32'h02020202; b2b_val[2] = 32'h03030303;
    for (int i = 0; i < 3; i++) preload(14'(b2b_addr[i] >> 2), b2b_val[i]);
    dok_n = 0; acc_n = 0;
    for (int i = 0; i < 4; i++) begin dok_c[i] = -1; acc_c[i] = -1; end
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      if (data_ok) begin
        if (dok_n < 3) chk($sformatf("b2b_rdata%0d", dok_n), rdata, b2b_val[dok_n]);
        if (dok_n < 4) dok_c[dok_n] = c;
        dok_n++;
      end
      if (acc_n < 3) begin req = 1'b1; wr = 1'b0; size = 2'd2; addr = b2b_addr[acc_n]; end
      else req = 1'b0;
      if (req && addr_ok) begin
        if (acc_n < 4) acc_c[acc_n] = c;
        acc_n++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    chk("b2b_dok_count", 32'(dok_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_accept_cyc%0d", i), 32'(acc_c[i]), 32'(2 * i));
      chk($sformatf("b2b_dok_cyc%0d", i), 32'(dok_c[i]), 32'(2 * i + 2));
    end

    // Reset while a read-modify-write is in its read phase.
    preload(14'h30, 32'h55667788);
    we0 = we_total;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd0; wstrb = 4'h1; addr = 32'hC0; wdata = 32'h000000FF;
    chk("rmw_rst_accept", 32'(addr_ok), 32'd1);
    @(negedge clk);
    req = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rmw_rst_we",      32'(ram_we),  32'd0);
    chk("rmw_rst_addr_ok", 32'(addr_ok), 32'd0);
    repeat (3) @(negedge clk);
    chk("rmw_rst_mem", mem[14'h30], 32'h55667788);
    resetn = 1'b1;
    @(negedge clk);
    chk("rmw_rel_addr_ok", 32'(addr_ok), 32'd1);
    chk("rmw_rel_data_ok", 32'(data_ok), 32'd0);
    repeat (2) @(negedge clk);
    chk("rmw_no_write", 32'(we_total - we0), 32'd0);
    chk("rmw_mem_after", mem[14'h30], 32'h55667788);

    // Word read at a misaligned byte address.
    we0 = we_total;
    txn(1'b0, 2'd2, 4'h0, 32'h42, 32'h0, lat, rd);
`ifdef SRAM_ALIGN_CHECK_EN
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_rdata",   rd,       32'hDEADBEEF);
    chk("mis_no_ram",  32'(we_total - we0), 32'd0);
    chk("mis_err",     32'(err), 32'd1);
    txn(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, lat, rd);
    chk("mis_next_rdata", rd, 32'h12345678);
    chk("mis_err_sticky", 32'(err), 32'd1);
`else
    chk("noalign_latency", 32'(lat), 32'd2);
    chk("noalign_rdata",   rd,       32'h12345678);
    chk("noalign_err",     32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
